// File: rtl/game_seq.sv
// game_seq: game flow sequencer (idle -> countdown -> play -> done) that
// drives the song time base, holds the note generator in reset, and
// stretches note pulses into timed buzzer bursts.
// Optional pause support is compiled in with `define GAME_SEQ_PAUSE_EN.
module game_seq #(
  parameter int COUNTDOWN_SEC = 3,
  parameter int NOTE_SOUND_MS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick_1ms,
  input  logic        i_btn_start,
  input  logic        i_btn_pause,
  input  logic        i_note_t1,
  input  logic        i_note_t2,
  input  logic [31:0] i_gen_pitch,
  input  logic        i_game_end,
  output logic [31:0] o_cur_time,
  output logic        o_gen_rst,
  output logic [2:0]  o_state,
  output logic [2:0]  o_countdown,
  output logic        o_buzz_en,
  output logic [31:0] o_buzz_pitch,
  output logic        o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  ms_cnt;
  logic [15:0] dur_cnt, dur_nxt;
  logic        sec_wrap;
  logic        note_hit;

`ifndef GAME_SEQ_PAUSE_EN
  // Pause button has no function in this build.
  logic unused_pause;
  assign unused_pause = i_btn_pause;
`endif

  // Tick that completes one countdown second.
  assign sec_wrap = i_tick_1ms && (ms_cnt == 10'd999);
  // Either track firing with a real pitch; both at once is one note.
  assign note_hit = (state == PLAY) && (i_note_t1 || i_note_t2) && (i_gen_pitch != 32'd0);

  // Next-state decode; end-of-song outranks pause.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_btn_start) state_nxt = COUNT;
      COUNT: if (sec_wrap && o_countdown == 3'd1) state_nxt = PLAY;
      PLAY: begin
        if (i_game_end) state_nxt = DONE;
`ifdef GAME_SEQ_PAUSE_EN
        else if (i_btn_pause) state_nxt = PAUSE;
`endif
      end
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE: if (i_btn_pause || i_btn_start) state_nxt = PLAY;
`endif
      DONE:  if (i_btn_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Note duration: anything but staying in PLAY silences; load beats tick.
  always_comb begin
    dur_nxt = dur_cnt;
    if (state_nxt != PLAY)
      dur_nxt = 16'd0;
    else if (note_hit)
      dur_nxt = 16'(NOTE_SOUND_MS);
    else if (i_tick_1ms && dur_cnt != 16'd0)
      dur_nxt = dur_cnt - 16'd1;
  end

  // State register and the flags derived directly from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_gen_rst <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_gen_rst <= (state_nxt == IDLE) || (state_nxt == COUNT);
      o_done    <= (state_nxt == DONE);
    end
  end

  // Countdown seconds and the ms sub-counter within each second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt      <= 10'd0;
      o_countdown <= 3'd0;
    end else if (state == IDLE && i_btn_start) begin
      ms_cnt      <= 10'd0;
      o_countdown <= 3'(COUNTDOWN_SEC);
    end else if (state == COUNT && i_tick_1ms) begin
      if (sec_wrap) begin
        ms_cnt      <= 10'd0;
        o_countdown <= o_countdown - 3'd1;
      end else begin
        ms_cnt <= ms_cnt + 10'd1;
      end
    end
  end

  // Game time: counts only in PLAY (including the exit cycle), saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_cur_time <= 32'd0;
    else if (state == IDLE || (state == DONE && i_btn_start))
      o_cur_time <= 32'd0;
    else if (state == PLAY && i_tick_1ms && o_cur_time != 32'hFFFF_FFFF)
      o_cur_time <= o_cur_time + 32'd1;
  end

  // Buzzer: enable mirrors the duration counter; pitch latches per note.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_cnt      <= 16'd0;
      o_buzz_en    <= 1'b0;
      o_buzz_pitch <= 32'd0;
    end else begin
      dur_cnt   <= dur_nxt;
      o_buzz_en <= (dur_nxt != 16'd0);
      if (note_hit && state_nxt == PLAY) o_buzz_pitch <= i_gen_pitch;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_game_seq.sv
// tb_game_seq: directed test of game_seq; inputs change on the falling
// edge and outputs are sampled on the following falling edge.
module tb_game_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic        t1 = 1'b0, t2 = 1'b0, game_end = 1'b0;
  logic [31:0] pitch = 32'd0;
  logic [31:0] cur_time, buzz_pitch;
  logic        gen_rst, buzz_en, done;
  logic [2:0]  state, countdown;

  int n_chk = 0;
  int n_pass = 0;

  game_seq #(.COUNTDOWN_SEC(3), .NOTE_SOUND_MS(100)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick_1ms(tick), .i_btn_start(start),
    .i_btn_pause(pause), .i_note_t1(t1), .i_note_t2(t2), .i_gen_pitch(pitch),
    .i_game_end(game_end), .o_cur_time(cur_time), .o_gen_rst(gen_rst),
    .o_state(state), .o_countdown(countdown), .o_buzz_en(buzz_en),
    .o_buzz_pitch(buzz_pitch), .o_done(done)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report on mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply the pulses set up so far for exactly one rising edge.
  task automatic step();
    @(negedge clk);
    tick = 1'b0; start = 1'b0; pause = 1'b0; t1 = 1'b0; t2 = 1'b0; game_end = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_gen_rst", 32'(gen_rst), 32'd1);
    chk("rst_cur_time", cur_time, 32'd0);
    chk("rst_countdown", 32'(countdown), 32'd0);
    chk("rst_buzz", {30'd0, buzz_en, done}, 32'd0);
    rst_n = 1'b1;
    step();

    // Countdown 3,2,1 with changes at ticks 1000 and 2000.
    start = 1'b1; step();
    chk("count_state", 32'(state), 32'd1);
    chk("count_cd3", 32'(countdown), 32'd3);
    ticks(999);  chk("cd3_t999", 32'(countdown), 32'd3);
    ticks(1);    chk("cd2_t1000", 32'(countdown), 32'd2);
    ticks(999);  chk("cd2_t1999", 32'(countdown), 32'd2);
    ticks(1);    chk("cd1_t2000", 32'(countdown), 32'd1);
    ticks(999);  chk("count_t2999", 32'(state), 32'd1);
    chk("gen_rst_t2999", 32'(gen_rst), 32'd1);
    ticks(1);
    chk("play_state", 32'(state), 32'd2);
    chk("play_cd0", 32'(countdown), 32'd0);
    chk("play_gen_rst", 32'(gen_rst), 32'd0);
    chk("play_time0", cur_time, 32'd0);

    start = 1'b1; step();
    chk("start_ign_play", 32'(state), 32'd2);

    ticks(1500);
    chk("time_1500", cur_time, 32'd1500);

`ifdef GAME_SEQ_PAUSE_EN
    pause = 1'b1; step();
    chk("pause_state", 32'(state), 32'd3);
    ticks(200);
    chk("pause_frozen", cur_time, 32'd1500);
    chk("pause_gen_rst", 32'(gen_rst), 32'd0);
    pause = 1'b1; step();
    chk("resume_state", 32'(state), 32'd2);
`else
    pause = 1'b1; step();
    chk("pause_ign", 32'(state), 32'd2);
    chk("pause_ign_time", cur_time, 32'd1500);
`endif
    ticks(1);
    chk("time_1501", cur_time, 32'd1501);

    // Dual-track note: single load, 100 ticks of sound.
    pitch = 32'd71586; t1 = 1'b1; t2 = 1'b1; step();
    chk("note_pitch", buzz_pitch, 32'd71586);
    chk("note_en", 32'(buzz_en), 32'd1);
    ticks(99);   chk("note_en_99", 32'(buzz_en), 32'd1);
    ticks(1);    chk("note_off_100", 32'(buzz_en), 32'd0);

    pitch = 32'd0; t1 = 1'b1; step();
    chk("rest_ign_en", 32'(buzz_en), 32'd0);
    chk("rest_ign_pitch", buzz_pitch, 32'd71586);

    // Retrigger on tick 50: load wins, sound ends 100 ticks later.
    pitch = 32'd71586; t1 = 1'b1; step();
    ticks(49);
    pitch = 32'd47778; t2 = 1'b1; tick = 1'b1; step();
    chk("retrig_pitch", buzz_pitch, 32'd47778);
    chk("retrig_en", 32'(buzz_en), 32'd1);
    ticks(99);   chk("retrig_en_99", 32'(buzz_en), 32'd1);
    ticks(1);    chk("retrig_off", 32'(buzz_en), 32'd0);
    chk("time_1751", cur_time, 32'd1751);

    // End of song with pause and tick in the same cycle while sounding.
    pitch = 32'd1234; t1 = 1'b1; step();
    chk("pre_done_en", 32'(buzz_en), 32'd1);
    game_end = 1'b1; pause = 1'b1; tick = 1'b1; step();
    chk("done_state", 32'(state), 32'd4);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_tick_counted", cur_time, 32'd1752);
    chk("done_buzz_off", 32'(buzz_en), 32'd0);
    chk("done_pitch_hold", buzz_pitch, 32'd1234);
    ticks(5);
    chk("done_frozen", cur_time, 32'd1752);
    pause = 1'b1; step();
    chk("done_pause_ign", 32'(state), 32'd4);
    start = 1'b1; step();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_time", cur_time, 32'd0);
    chk("idle_gen_rst", 32'(gen_rst), 32'd1);
    chk("idle_done", 32'(done), 32'd0);

    // Asynchronous reset mid-PLAY with the buzzer on.
    start = 1'b1; step();
    ticks(3000);
    ticks(4000);
    chk("time_4000", cur_time, 32'd4000);
    pitch = 32'd500; t1 = 1'b1; step();
    chk("pre_rst_en", 32'(buzz_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_time", cur_time, 32'd0);
    chk("arst_gen_rst", 32'(gen_rst), 32'd1);
    chk("arst_buzz", {29'd0, buzz_en, done, 1'b0}, 32'd0);
    chk("arst_pitch", buzz_pitch, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_time", cur_time, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_seq.md
GAME_SEQ -- requirements
Module: game_seq

Interface
REQ-001 SHALL have parameter COUNTDOWN_SEC, default 3: pre-game countdown length in seconds (1..7).
REQ-002 SHALL have parameter NOTE_SOUND_MS, default 100: buzzer on-time per generated note, in ms (1..65535).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_tick_1ms, input, 1: one-cycle pulse every 1 ms.
REQ-006 SHALL have port i_btn_start, input, 1: debounced one-cycle start pulse.
REQ-007 SHALL have port i_btn_pause, input, 1: debounced one-cycle pause/resume pulse.
REQ-008 SHALL have ports i_note_t1 and i_note_t2, input, 1 each: note-generator track pulses.
REQ-009 SHALL have port i_gen_pitch, input, 32: note-generator pitch (half-period count); 0 means rest.
REQ-010 SHALL have port i_game_end, input, 1: note-generator end-of-song level.
REQ-011 SHALL have port o_cur_time, output, 32: game time in ms, fed to the note generator.
REQ-012 SHALL have port o_gen_rst, output, 1: active-high hold-in-reset for the note generator.
REQ-013 SHALL have port o_state, output, 3: current FSM state code.
REQ-014 SHALL have port o_countdown, output, 3: remaining countdown seconds; 0 outside COUNT.
REQ-015 SHALL have port o_buzz_en, output, 1: buzzer enable.
REQ-016 SHALL have port o_buzz_pitch, output, 32: buzzer pitch.
REQ-017 SHALL have port o_done, output, 1: high while in DONE.

Function
REQ-018 SHALL implement an FSM with states IDLE=0, COUNT=1, PLAY=2, PAUSE=3 and DONE=4; all outputs are registered.
REQ-019 IDLE: o_gen_rst=1 and o_cur_time=0; i_btn_start moves to COUNT, loading o_countdown=COUNTDOWN_SEC and clearing a 10-bit ms sub-counter.
REQ-020 COUNT: o_gen_rst=1; each tick increments the sub-counter. At 999 it wraps to 0 and decrements o_countdown. The tick that decrements o_countdown from 1 moves to PLAY with o_countdown=0.
REQ-021 PLAY: o_gen_rst=0; each tick increments o_cur_time by 1 (visible the cycle after the tick) and saturates at 0xFFFFFFFF.
REQ-022 PLAY: i_game_end=1 moves to DONE. i_btn_pause moves to PAUSE. When both occur in the same cycle, DONE wins. A tick in the same cycle is still counted.
REQ-023 PAUSE: o_cur_time frozen; o_gen_rst=0 (generator state kept); o_buzz_en forced 0 and the duration counter cleared; i_btn_pause or i_btn_start returns to PLAY.
REQ-024 DONE: o_done=1, o_cur_time frozen, o_gen_rst=0; i_btn_start moves to IDLE, clearing o_cur_time.
REQ-025 i_btn_start SHALL be ignored in COUNT and PLAY. i_btn_pause SHALL be ignored outside PLAY and PAUSE.
REQ-026 Buzzer, PLAY only: (i_note_t1 | i_note_t2) with i_gen_pitch!=0 latches o_buzz_pitch and loads a 16-bit duration counter with NOTE_SOUND_MS in the next cycle.
REQ-027 Buzzer pulses: both tracks pulsing in the same cycle SHALL cause a single load. A new note during sound SHALL reload the counter and pitch (retrigger). A note with pitch 0 SHALL be ignored.
REQ-028 Buzzer timing: the duration counter decrements on each tick while nonzero; o_buzz_en = (counter != 0). A load and a tick in the same cycle SHALL give load priority.
REQ-029 Leaving PLAY to DONE SHALL clear the duration counter; o_buzz_pitch holds its last value.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, o_cur_time=0, o_gen_rst=1, o_countdown=0, o_buzz_en=0, o_buzz_pitch=0, o_done=0, and all counters 0.
REQ-031 Reset asserted mid-PLAY or mid-PAUSE SHALL discard time and sound. Release SHALL resume in IDLE with no start pulse replayed.

Configuration
REQ-032 Macro GAME_SEQ_PAUSE_EN defined: PAUSE state and i_btn_pause behave per REQ-022/023.
REQ-033 GAME_SEQ_PAUSE_EN undefined: PAUSE logic is not compiled, i_btn_pause is ignored, and state code 3 is unreachable.

Verification
REQ-034 Reset, then start pulse, then 3000 ticks -> COUNT with o_countdown 3,2,1 changing at ticks 1000 and 2000; PLAY and o_countdown=0 after tick 3000; o_gen_rst falls in the same cycle.
REQ-035 PLAY with 1500 ticks -> o_cur_time=1500. Then pause, 200 ticks, pause -> o_cur_time still 1500 after the 200 ticks, and 1501 after the next tick.
REQ-036 Same-cycle i_note_t1=i_note_t2=1 with pitch 71586 -> o_buzz_pitch=71586, o_buzz_en high for exactly 100 ticks. Pitch 47778 at tick 50 -> retrigger, sound ends 100 ticks after tick 50.
REQ-037 i_game_end and i_btn_pause in the same cycle -> DONE, o_done=1. Then start -> IDLE, o_cur_time=0, o_gen_rst=1.
REQ-038 rst_n low mid-PLAY with o_cur_time=4000 and the buzzer on -> all outputs at reset values immediately, without waiting for a clock edge. Build without GAME_SEQ_PAUSE_EN -> pause pulse in PLAY leaves o_state=2.
